// File: rtl/hc595_ctrl.sv
// Serialises seg/sel into two chained 74HC595s (seg first, LSB first; then sel[5]..sel[0]).
// A frame is sent on any change of {seg,sel}, and once after every reset.
module hc595_ctrl #(
    parameter int DIV = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] seg,
    input  logic [5:0] sel,
    output logic       ds,
    output logic       shcp,
    output logic       stcp,
    output logic       oe,
    output logic       busy
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          half_q, half_d;
    logic [3:0]    bit_q, bit_d;
    logic [13:0]   shadow_q, shadow_d;
    logic [13:0]   last_q, last_d;
    logic          first_q, first_d;
    logic          ds_q, ds_d;
    logic          shcp_q, shcp_d;
    logic          stcp_q, stcp_d;
    logic          oe_q, oe_d;
    logic          busy_q, busy_d;

    logic [13:0] ser_w;
    logic [13:0] frame_w;
    logic        start;
    logic        launch;

    // ser_w[k] is the k-th bit on the wire
    assign ser_w   = {sel[0], sel[1], sel[2], sel[3], sel[4], sel[5], seg};
    assign frame_w = {seg, sel};
    assign start   = first_q || (frame_w != last_q);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        half_d   = half_q;
        bit_d    = bit_q;
        shadow_d = shadow_q;
        last_d   = last_q;
        first_d  = first_q;
        ds_d     = ds_q;
        shcp_d   = shcp_q;
        stcp_d   = stcp_q;
        oe_d     = oe_q;
        busy_d   = busy_q;
        launch   = 1'b0;

        unique case (state_q)
            IDLE: begin
                ds_d   = 1'b0;
                shcp_d = 1'b0;
                stcp_d = 1'b0;
                busy_d = 1'b0;
                launch = start;
            end
            SHIFT: begin
                if (div_q != DIV_MAX) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (!half_q) begin
                        half_d = 1'b1;
                        shcp_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        shcp_d = 1'b0;
                        if (bit_q == 4'd13) begin
                            state_d = LATCH;
                            ds_d    = 1'b0;
                            stcp_d  = 1'b1;
                            oe_d    = 1'b0;
                        end else begin
                            bit_d = bit_q + 4'd1;
                            ds_d  = shadow_q[bit_q + 4'd1];
                        end
                    end
                end
            end
            LATCH: begin
                if (div_q != DIV_MAX) begin
                    div_d = div_q + 1'b1;
                end else begin
                    // the exit edge doubles as the idle check
                    state_d = IDLE;
                    div_d   = '0;
                    stcp_d  = 1'b0;
                    busy_d  = 1'b0;
                    launch  = start;
                end
            end
            default: begin
                state_d = IDLE;
                ds_d    = 1'b0;
                shcp_d  = 1'b0;
                stcp_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        if (launch) begin
            state_d  = SHIFT;
            shadow_d = ser_w;
            last_d   = frame_w;
            first_d  = 1'b0;
            div_d    = '0;
            half_d   = 1'b0;
            bit_d    = 4'd0;
            ds_d     = ser_w[0];
            shcp_d   = 1'b0;
            stcp_d   = 1'b0;
            busy_d   = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            div_q    <= '0;
            half_q   <= 1'b0;
            bit_q    <= 4'd0;
            shadow_q <= '0;
            last_q   <= '0;
            first_q  <= 1'b1;
            ds_q     <= 1'b0;
            shcp_q   <= 1'b0;
            stcp_q   <= 1'b0;
            oe_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            half_q   <= half_d;
            bit_q    <= bit_d;
            shadow_q <= shadow_d;
            last_q   <= last_d;
            first_q  <= first_d;
            ds_q     <= ds_d;
            shcp_q   <= shcp_d;
            stcp_q   <= stcp_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
        end
    end

    assign ds   = ds_q;
    assign shcp = shcp_q;
    assign stcp = stcp_q;
    assign oe   = oe_q;
    assign busy = busy_q;

endmodule
